id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register for the 5-stage RISC-V core. Sits directly downstream of the

---
 rtl/id_ex_hazard_reg.sv | 93 +++++++++
 tb/tb_id_ex_hazard_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle bubble
// insertion, PC / IF-ID write gating and a saturating bubble counter.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1addr_i,
  input  logic [4:0]        id_rs2addr_i,
  input  logic [4:0]        id_rdaddr_i,
  input  logic [DATA_W-1:0] id_rs1data_i,
  input  logic [DATA_W-1:0] id_rs2data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [7:0]        id_ctrl_i,
  output logic              ex_valid_o,
  output logic [4:0]        ex_rs1addr_o,
  output logic [4:0]        ex_rs2addr_o,
  output logic [4:0]        ex_rdaddr_o,
  output logic [DATA_W-1:0] ex_rs1data_o,
  output logic [DATA_W-1:0] ex_rs2data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [7:0]        ex_ctrl_o,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ex_memread;
  logic rd_matches;
  logic take_bubble;

  // A load in EX whose destination feeds the instruction in ID must wait a cycle.
  assign ex_memread  = ex_ctrl_o[6];
  assign rd_matches  = (ex_rdaddr_o == id_rs1addr_i) || (ex_rdaddr_o == id_rs2addr_i);
  assign hazard_o    = ex_valid_o && ex_memread && id_valid_i &&
                       (ex_rdaddr_o != 5'd0) && rd_matches;
  assign pc_write_o   = ~hazard_o & ~stall_i;
  assign ifid_write_o = ~hazard_o & ~stall_i;
  assign take_bubble  = !flush_i && !stall_i && hazard_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o   <= 1'b0;
      ex_rs1addr_o <= '0;
      ex_rs2addr_o <= '0;
      ex_rdaddr_o  <= '0;
      ex_rs1data_o <= '0;
      ex_rs2data_o <= '0;
      ex_imm_o     <= '0;
      ex_ctrl_o    <= '0;
    end else if (flush_i) begin
      // A flushed slot still captures operands so the forwarding unit sees stable indices.
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= '0;
      ex_rs1addr_o <= id_rs1addr_i;
      ex_rs2addr_o <= id_rs2addr_i;
      ex_rdaddr_o  <= id_rdaddr_i;
      ex_rs1data_o <= id_rs1data_i;
      ex_rs2data_o <= id_rs2data_i;
      ex_imm_o     <= id_imm_i;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (hazard_o) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end else begin
      ex_valid_o   <= id_valid_i;
      ex_ctrl_o    <= id_ctrl_i;
      ex_rs1addr_o <= id_rs1addr_i;
      ex_rs2addr_o <= id_rs2addr_i;
      ex_rdaddr_o  <= id_rdaddr_i;
      ex_rs1data_o <= id_rs1data_i;
      ex_rs2data_o <= id_rs2data_i;
      ex_imm_o     <= id_imm_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (take_bubble && (bubble_cnt_o != CNT_MAX)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: a per-cycle reference model plus literal
// checks for reset, load-use bubbles, x0, stall, flush and counter saturation.
module tb_id_ex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] id_d1 = '0, id_d2 = '0, id_imm = '0;
  logic [7:0]  id_ctrl = '0;

  logic        ex_valid, hazard, pc_write, ifid_write;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] bcnt;

  logic        ex_valid2, hazard2, pc_write2, ifid_write2;
  logic [4:0]  ex_rs1_2, ex_rs2_2, ex_rd2;
  logic [31:0] ex_d1_2, ex_d2_2, ex_imm2;
  logic [7:0]  ex_ctrl2;
  logic [1:0]  bcnt2;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  localparam logic [7:0] LW  = 8'hD8;
  localparam logic [7:0] ADD = 8'h82;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs1addr_i(id_rs1), .id_rs2addr_i(id_rs2),
    .id_rdaddr_i(id_rd), .id_rs1data_i(id_d1), .id_rs2data_i(id_d2),
    .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .ex_valid_o(ex_valid), .ex_rs1addr_o(ex_rs1), .ex_rs2addr_o(ex_rs2),
    .ex_rdaddr_o(ex_rd), .ex_rs1data_o(ex_d1), .ex_rs2data_o(ex_d2),
    .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .hazard_o(hazard),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .bubble_cnt_o(bcnt)
  );

  id_ex_hazard_reg #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs1addr_i(id_rs1), .id_rs2addr_i(id_rs2),
    .id_rdaddr_i(id_rd), .id_rs1data_i(id_d1), .id_rs2data_i(id_d2),
    .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .ex_valid_o(ex_valid2), .ex_rs1addr_o(ex_rs1_2), .ex_rs2addr_o(ex_rs2_2),
    .ex_rdaddr_o(ex_rd2), .ex_rs1data_o(ex_d1_2), .ex_rs2data_o(ex_d2_2),
    .ex_imm_o(ex_imm2), .ex_ctrl_o(ex_ctrl2), .hazard_o(hazard2),
    .pc_write_o(pc_write2), .ifid_write_o(ifid_write2), .bubble_cnt_o(bcnt2)
  );

  // Reference model: the instruction occupying EX as a record, plus a plain bubble tally.
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [7:0]  m_ctrl;
  int          m_bubbles;

  function automatic bit model_hazard();
    bit ex_is_load = m_valid && m_ctrl[6] && (m_rd != 5'd0);
    return ex_is_load && id_valid && ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0; m_bubbles = 0;
    end else if (flush) begin
      m_valid = 0; m_ctrl = 0;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm;
    end else if (!stall) begin
      if (model_hazard()) begin
        m_valid = 0; m_ctrl = 0; m_bubbles++;
      end else begin
        m_valid = id_valid; m_ctrl = id_ctrl;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
        m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      bit h;
      h = model_hazard();
      check_output("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
      check_output("ex_rs1", {27'b0, ex_rs1}, {27'b0, m_rs1});
      check_output("ex_rs2", {27'b0, ex_rs2}, {27'b0, m_rs2});
      check_output("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
      check_output("ex_d1", ex_d1, m_d1);
      check_output("ex_d2", ex_d2, m_d2);
      check_output("ex_imm", ex_imm, m_imm);
      check_output("ex_ctrl", {24'b0, ex_ctrl}, {24'b0, m_ctrl});
      check_output("hazard", {31'b0, hazard}, {31'b0, h});
      check_output("pc_write", {31'b0, pc_write}, {31'b0, !h && !stall});
      check_output("ifid_write", {31'b0, ifid_write}, {31'b0, !h && !stall});
      check_output("bubble_cnt", {16'b0, bcnt}, (m_bubbles > 65535) ? 32'd65535 : m_bubbles);
      check_output("bubble_cnt_sat", {30'b0, bcnt2}, (m_bubbles > 3) ? 32'd3 : m_bubbles);
      check_output("ex_valid_w2", {31'b0, ex_valid2}, {31'b0, m_valid});
      check_output("ex_rd_w2", {27'b0, ex_rd2}, {27'b0, m_rd});
    end
  end

  // Present one ID-stage instruction plus the stall/flush controls.
  task automatic apply_stimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic [7:0] c,
                                input logic st, input logic fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = c;
    id_d1 = 32'h1000_0000 + {27'b0, r1};
    id_d2 = 32'h2000_0000 + {27'b0, r2};
    id_imm = 32'hFFFF_F000 | {27'b0, rd};
    stall = st; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_pair(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    apply_stimulus(1, 5'd1, 5'd0, rd, LW, 0, 0); tick();
    apply_stimulus(1, r1, r2, 5'd10, ADD, 0, 0);
    check_output("pair_hazard", {31'b0, hazard}, 32'd1);
    tick();
    apply_stimulus(1, r1, r2, 5'd10, ADD, 0, 0);
    check_output("pair_hazard_drop", {31'b0, hazard}, 32'd0);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    started = 1;
    check_output("reset_valid", {31'b0, ex_valid}, 32'd0);
    check_output("reset_cnt", {16'b0, bcnt}, 32'd0);

    // Load into x5, then a dependent add: exactly one bubble.
    apply_stimulus(1, 5'd2, 5'd0, 5'd5, LW, 0, 0); tick();
    apply_stimulus(1, 5'd5, 5'd1, 5'd6, ADD, 0, 0);
    check_output("t2_hazard", {31'b0, hazard}, 32'd1);
    check_output("t2_pc_write", {31'b0, pc_write}, 32'd0);
    tick();
    check_output("t2_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check_output("t2_bubble_rd_hold", {27'b0, ex_rd}, 32'd5);
    check_output("t2_cnt", {16'b0, bcnt}, 32'd1);
    apply_stimulus(1, 5'd5, 5'd1, 5'd6, ADD, 0, 0);
    check_output("t2_hazard_drop", {31'b0, hazard}, 32'd0);
    tick();
    check_output("t2_add_valid", {31'b0, ex_valid}, 32'd1);
    check_output("t2_add_rd", {27'b0, ex_rd}, 32'd6);

    // Load to x0 never stalls.
    apply_stimulus(1, 5'd2, 5'd0, 5'd0, LW, 0, 0); tick();
    apply_stimulus(1, 5'd0, 5'd0, 5'd6, ADD, 0, 0);
    check_output("t3_hazard", {31'b0, hazard}, 32'd0);
    tick();
    check_output("t3_cnt", {16'b0, bcnt}, 32'd1);

    // Hazard under stall holds everything; bubble lands once stall releases.
    apply_stimulus(1, 5'd3, 5'd0, 5'd7, LW, 0, 0); tick();
    apply_stimulus(1, 5'd7, 5'd4, 5'd8, ADD, 1, 0); tick();
    apply_stimulus(1, 5'd7, 5'd4, 5'd8, ADD, 1, 0);
    check_output("t4_hazard_stalled", {31'b0, hazard}, 32'd1);
    tick();
    check_output("t4_hold_valid", {31'b0, ex_valid}, 32'd1);
    check_output("t4_hold_ctrl", {24'b0, ex_ctrl}, {24'b0, LW});
    check_output("t4_hold_cnt", {16'b0, bcnt}, 32'd1);
    apply_stimulus(1, 5'd7, 5'd4, 5'd8, ADD, 0, 0); tick();
    check_output("t4_bubble_cnt", {16'b0, bcnt}, 32'd2);
    apply_stimulus(1, 5'd7, 5'd4, 5'd8, ADD, 0, 0); tick();
    check_output("t4_advance_rd", {27'b0, ex_rd}, 32'd8);

    // Flush beats stall; operand fields still load.
    apply_stimulus(1, 5'd11, 5'd12, 5'd13, 8'hFF, 1, 1); tick();
    check_output("t5_valid", {31'b0, ex_valid}, 32'd0);
    check_output("t5_ctrl", {24'b0, ex_ctrl}, 32'd0);
    check_output("t5_rd", {27'b0, ex_rd}, 32'd13);

    // rs2 match, both-match, then more bubbles to saturate the 2-bit counter.
    load_use_pair(5'd9, 5'd3, 5'd9);
    check_output("rs2_match_cnt", {16'b0, bcnt}, 32'd3);
    load_use_pair(5'd9, 5'd9, 5'd9);
    check_output("both_match_cnt", {16'b0, bcnt}, 32'd4);
    load_use_pair(5'd14, 5'd14, 5'd0);
    check_output("t6_cnt_wide", {16'b0, bcnt}, 32'd5);
    check_output("t6_cnt_sat", {30'b0, bcnt2}, 32'd3);
    load_use_pair(5'd15, 5'd0, 5'd15);
    check_output("t6_cnt_held", {30'b0, bcnt2}, 32'd3);

    // Reset asserted mid-hazard clears everything at once.
    apply_stimulus(1, 5'd2, 5'd0, 5'd16, LW, 0, 0); tick();
    apply_stimulus(1, 5'd16, 5'd0, 5'd17, ADD, 1, 0);
    rst = 1; #1;
    check_output("t1_valid", {31'b0, ex_valid}, 32'd0);
    check_output("t1_rd", {27'b0, ex_rd}, 32'd0);
    check_output("t1_cnt", {16'b0, bcnt}, 32'd0);
    check_output("t1_hazard", {31'b0, hazard}, 32'd0);
    tick();
    rst = 0;
    apply_stimulus(1, 5'd16, 5'd0, 5'd17, ADD, 0, 0); tick();
    check_output("post_reset_load", {27'b0, ex_rd}, 32'd17);
    check_output("post_reset_valid", {31'b0, ex_valid}, 32'd1);
    apply_stimulus(0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 0); tick();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
